dmem_responder: RTL and testbench

- Handshaked data-memory responder for the core's data port; the target end of the core-initiated load/store interface.
- Replaces the zero-latency combinational dmem when the core runs over a valid/ready memory bus.
- Accepts one request at a time, models a fixed access latency, applies byte strobes on stores, and flags misaligned or out-of-range accesses.

---
 rtl/common_pkg.sv | 19 +
 rtl/dmem_responder_array.sv | 17 +
 rtl/dmem_responder.sv | 70 +++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// common: shared core types plus the data-memory request/response bundle.
package common;
  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;
  typedef logic [7:0]  u8;
  typedef logic        u1;
  typedef logic [7:0]  strobe_t;
  typedef struct packed {
    u32      addr;
    u1       we;
    strobe_t strobe;
    word_t   wdata;
  } dmem_req_t;
  typedef struct packed {
    word_t rdata;
    u1     err;
  } dmem_resp_t;
  localparam u32 DMEM_BASE = 32'h8000_0000;
endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH_WORDS x 64 storage with per-byte write enables and combinational read.
module dmem_array import common::*; #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [IW-1:0] index,
  input  strobe_t       be,
  input  word_t         wdata,
  output word_t         rdata
);
  word_t mem [DEPTH_WORDS];
  assign rdata = mem[index];
  always_ff @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory target with fixed latency, byte strobes and access-error flagging.
module dmem_responder import common::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2,
  parameter u32 BASE_ADDR = DMEM_BASE
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    req_valid,
  output logic    req_ready,
  input  u32      req_addr,
  input  logic    req_we,
  input  strobe_t req_strobe,
  input  word_t   req_wdata,
  output logic    resp_valid,
  input  logic    resp_ready,
  output word_t   resp_rdata,
  output logic    resp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  dmem_req_t  req_q;
  dmem_resp_t resp_q;
  u32         off;
  logic       enter, err;
  strobe_t    be;
  word_t      rdata;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = resp_q.rdata;
  assign resp_err   = resp_q.err;
  // wrap-around of addr - BASE_ADDR is caught by the explicit addr < BASE_ADDR test
  always_comb begin
    off   = req_q.addr - BASE_ADDR;
    err   = (req_q.addr[2:0] != 3'd0) || (req_q.addr < BASE_ADDR) || ((off >> 3) >= u32'(DEPTH_WORDS));
    enter = state == WAIT && cnt == 4'd0;
    be    = (enter && req_q.we && !err) ? req_q.strobe : '0;
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .index(off[IW+2:3]),
    .be   (be),
    .wdata(req_q.wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      req_q  <= '0;
      resp_q <= '0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        req_q <= '{addr: req_addr, we: req_we, strobe: req_strobe, wdata: req_wdata};
        cnt   <= LOAD;
        state <= WAIT;
      end
    end else if (state == WAIT) begin
      cnt    <= enter ? cnt : cnt - 4'd1;
      state  <= enter ? RESP : WAIT;
      resp_q <= enter ? dmem_resp_t'{rdata: (err || req_q.we) ? word_t'(0) : rdata, err: err} : resp_q;
    end else if (resp_ready) begin
      state  <= IDLE;
      resp_q <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responders (LATENCY 2 and 1) against a byte-level memory model.
module tb_dmem_responder;
  import common::*;
  localparam int DEPTH = 1024;
  localparam u32 BASE = 32'h8000_0000;
  logic clk = 1'b0, rst0 = 1'b1, rst1 = 1'b1, v0 = 1'b0, v1 = 1'b0, we = 1'b0, rrdy = 1'b0, sel = 1'b0;
  u32 addr = '0;
  strobe_t strobe = '0;
  word_t wdata = '0;
  logic rq0, rq1, rv0, rv1, er0, er1;
  word_t rd0, rd1;
  logic rq_m, rv_m, er_m;
  word_t rd_m;
  int total = 0, bad = 0;
  word_t mm [int];
  always #5 clk = ~clk;
  assign rq_m = sel ? rq1 : rq0;
  assign rv_m = sel ? rv1 : rv0;
  assign er_m = sel ? er1 : er0;
  assign rd_m = sel ? rd1 : rd0;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .reset(rst0), .req_valid(v0), .req_ready(rq0), .req_addr(addr), .req_we(we),
    .req_strobe(strobe), .req_wdata(wdata), .resp_valid(rv0), .resp_ready(rrdy),
    .resp_rdata(rd0), .resp_err(er0));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rq1), .req_addr(addr), .req_we(we),
    .req_strobe(strobe), .req_wdata(wdata), .resp_valid(rv1), .resp_ready(rrdy),
    .resp_rdata(rd1), .resp_err(er1));
  task automatic model(input bit s, input u32 a, input bit w, input strobe_t st, input word_t d,
                       output word_t rd, output bit er);
    longint off;
    int key;
    off = longint'(a) - longint'(BASE);
    er = (a % 8 != 0) || off < 0 || off / 8 >= DEPTH;
    rd = '0;
    if (er) return;
    key = int'(off / 8) + (s ? DEPTH : 0);
    if (!w) rd = mm.exists(key) ? mm[key] : 'x;
    else begin
      if (!mm.exists(key)) mm[key] = '0;
      for (int b = 0; b < 8; b++) if (st[b]) mm[key][8*b +: 8] = d[8*b +: 8];
    end
  endtask
  task automatic issue(input bit s, input u32 a, input bit w, input strobe_t st, input word_t d);
    int lat;
    sel = s; addr = a; we = w; strobe = st; wdata = d; rrdy = 1'b0;
    total++;
    if (rq_m !== 1'b1) begin bad++; $display("FAIL issue_ready got=%b want=1", rq_m); end
    if (s) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    lat = 0;
    while (rv_m !== 1'b1 && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    total++;
    if (lat != (s ? 1 : 2)) begin bad++; $display("FAIL latency dut%0d got=%0d want=%0d", s, lat, s ? 1 : 2); end
  endtask
  task automatic finish_resp(input int hold);
    repeat (hold) @(negedge clk);
    rrdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rrdy = 1'b0;
    total++;
    if (rv_m !== 1'b0 || rq_m !== 1'b1) begin bad++; $display("FAIL handshake valid=%b ready=%b want 0/1", rv_m, rq_m); end
  endtask
  task automatic txn(input bit s, input u32 a, input bit w, input strobe_t st, input word_t d, input int hold,
                     output word_t rd, output bit er);
    issue(s, a, w, st, d);
    rd = rd_m; er = er_m;
    finish_resp(hold);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      total++;
      if (rq_m !== 1'b1 || rv_m !== 1'b0 || rd_m !== 64'h0 || er_m !== 1'b0) begin
        bad++; $display("FAIL reset_state dut%0d ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", s, rq_m, rv_m, rd_m, er_m);
      end
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_round_trip;
    word_t rd; bit er;
    txn(0, 32'h8000_0010, 1, 8'hFF, 64'h1122_3344_5566_7788, 0, rd, er);
    total++;
    if (er !== 1'b0 || rd !== 64'h0) begin bad++; $display("FAIL store_resp rdata=%h err=%b want 0/0", rd, er); end
    txn(0, 32'h8000_0010, 0, 8'h00, 64'h0, 0, rd, er);
    total++;
    if (er !== 1'b0 || rd !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL load_back rdata=%h err=%b want 1122334455667788/0", rd, er); end
  endtask
  task automatic test_strobe;
    word_t rd; bit er;
    txn(0, 32'h8000_0010, 1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, er);
    txn(0, 32'h8000_0010, 0, 8'hFF, 64'h0, 0, rd, er);
    total++;
    if (er !== 1'b0 || rd !== 64'h1122_3344_FFFF_FFFF) begin bad++; $display("FAIL strobe_merge rdata=%h want 11223344ffffffff", rd); end
  endtask
  task automatic test_errors;
    u32 bad_addr [4];
    word_t rd; bit er;
    bad_addr = '{32'h8000_0014, 32'h7FFF_FFF8, BASE + u32'(DEPTH * 8), 32'h8000_0011};
    foreach (bad_addr[i]) begin
      txn(0, bad_addr[i], i == 3, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 0, rd, er);
      total++;
      if (er !== 1'b1 || rd !== 64'h0) begin bad++; $display("FAIL error_%h rdata=%h err=%b want 0/1", bad_addr[i], rd, er); end
    end
    txn(0, BASE + u32'((DEPTH - 1) * 8), 0, 8'h00, 64'h0, 0, rd, er);
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL last_word err=%b want 0", er); end
    txn(0, 32'h8000_0010, 0, 8'h00, 64'h0, 0, rd, er);
    total++;
    if (rd !== 64'h1122_3344_FFFF_FFFF) begin bad++; $display("FAIL error_no_write rdata=%h want 11223344ffffffff", rd); end
  endtask
  task automatic test_backpressure;
    issue(0, 32'h8000_0010, 0, 8'h00, 64'h0);
    addr = 32'h8000_0018; we = 1'b1; wdata = 64'h5555; v0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rv_m !== 1'b1 || rq_m !== 1'b0 || rd_m !== 64'h1122_3344_FFFF_FFFF) begin
        bad++; $display("FAIL backpressure cyc%0d valid=%b ready=%b rdata=%h want 1/0/11223344ffffffff", c, rv_m, rq_m, rd_m);
      end
    end
    v0 = 1'b0;
    finish_resp(0);
  endtask
  task automatic test_async_reset;
    issue(0, 32'h8000_0010, 0, 8'h00, 64'h0);
    #2 rst0 = 1'b1;
    #1;
    total++;
    if (rv_m !== 1'b0 || rq_m !== 1'b1 || rd_m !== 64'h0 || er_m !== 1'b0) begin
      bad++; $display("FAIL async_reset valid=%b ready=%b rdata=%h err=%b want 0/1/0/0", rv_m, rq_m, rd_m, er_m);
    end
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_random;
    int idxs [17];
    word_t rd, erd; bit er, eer;
    u32 a; bit w; strobe_t st; word_t d; int r;
    for (int i = 0; i < 16; i++) idxs[i] = i;
    idxs[16] = DEPTH - 1;
    foreach (idxs[i]) begin
      a = BASE + u32'(idxs[i] * 8); d = {$urandom(), $urandom()};
      model(0, a, 1, 8'hFF, d, erd, eer);
      txn(0, a, 1, 8'hFF, d, 0, rd, er);
    end
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      a = BASE + u32'(idxs[$urandom_range(0, 16)] * 8);
      if (r == 7) a = a + u32'($urandom_range(1, 7));
      if (r == 8) a = BASE - u32'(8 * $urandom_range(1, 4096));
      if (r == 9) a = BASE + u32'(DEPTH * 8) + u32'(8 * $urandom_range(0, 100000));
      w = $urandom_range(0, 1) == 1; st = u8'($urandom()); d = {$urandom(), $urandom()};
      model(0, a, w, st, d, erd, eer);
      txn(0, a, w, st, d, $urandom_range(0, 3), rd, er);
      total++;
      if (rd !== erd || er !== eer) begin bad++; $display("FAIL random%0d addr=%h we=%b rdata=%h err=%b want %h/%b", n, a, w, rd, er, erd, eer); end
    end
  endtask
  task automatic test_reset_mid_wait(input bit s);
    word_t rd; bit er;
    txn(s, 32'h8000_0020, 1, 8'hFF, 64'h0BAD_F00D_0000_1234, 0, rd, er);
    sel = s; addr = 32'h8000_0020; we = 1'b1; strobe = 8'hFF; wdata = 64'hDEAD;
    if (s) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    if (s) rst1 = 1'b1; else rst0 = 1'b1;
    #1;
    total++;
    if (rv_m !== 1'b0 || rq_m !== 1'b1) begin bad++; $display("FAIL mid_wait_reset dut%0d valid=%b ready=%b want 0/1", s, rv_m, rq_m); end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    txn(s, 32'h8000_0020, 0, 8'h00, 64'h0, 0, rd, er);
    total++;
    if (rd !== 64'h0BAD_F00D_0000_1234 || er !== 1'b0) begin bad++; $display("FAIL abandoned_store dut%0d rdata=%h want 0badf00d00001234", s, rd); end
  endtask
  initial begin
    test_reset;
    test_round_trip;
    test_strobe;
    test_errors;
    test_backpressure;
    test_async_reset;
    test_random;
    test_reset_mid_wait(0);
    test_reset_mid_wait(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
